// File: rtl/parser_typedefs_pkg.sv
// Shared types and defaults for the PHS parser cluster.
package parser_typedefs_pkg;

   localparam int unsigned PHS_WIDTH_DEFAULT = 120;

   typedef enum logic {
      ARB_EMPTY,
      ARB_HOLD
   } arb_state_e;

endpackage

// File: rtl/phs_arbiter_if.sv
// Bus bundle between the parser array, the PHS arbiter and the downstream consumer.
interface phs_arbiter_if #(
   parameter int unsigned NUM_PARSERS = 4,
   parameter int unsigned PHS_WIDTH   = parser_typedefs_pkg::PHS_WIDTH_DEFAULT
);
   localparam int unsigned SRC_W = $clog2(NUM_PARSERS);

   logic [NUM_PARSERS*PHS_WIDTH-1:0] phs_i;
   logic [NUM_PARSERS-1:0]           phs_valid_i;
   logic [PHS_WIDTH-1:0]             phs_o;
   logic                             phs_valid_o;
   logic                             phs_ready_i;
   logic [SRC_W-1:0]                 phs_src_o;
   logic [NUM_PARSERS-1:0]           drop_o;
   logic [15:0]                      drop_cnt_o;

   modport master (
      output phs_i, phs_valid_i, phs_ready_i,
      input  phs_o, phs_valid_o, phs_src_o, drop_o, drop_cnt_o
   );

   modport slave (
      input  phs_i, phs_valid_i, phs_ready_i,
      output phs_o, phs_valid_o, phs_src_o, drop_o, drop_cnt_o
   );

endinterface

// File: rtl/phs_fifo.sv
// Per-parser PHS word FIFO; a full FIFO still accepts a write when it is popped in the same cycle.
module phs_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 120
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_wr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_rd,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_push;
   logic             w_pop;

   // Extra MSB on each pointer separates full from empty when the indices match.
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop   = i_rd && !o_empty;
   assign w_push  = i_wr && (!o_full || w_pop);
   assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
   end

endmodule

// File: rtl/phs_arbiter.sv
// Round-robin merge of NUM_PARSERS PHS streams into one registered valid/ready output,
// with per-parser FIFOs and saturating drop accounting.
module phs_arbiter
   import parser_typedefs_pkg::*;
#(
   parameter int unsigned NUM_PARSERS = 4,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned PHS_WIDTH   = PHS_WIDTH_DEFAULT
) (
   input logic          CLK,
   input logic          reset_n,
   phs_arbiter_if.slave bus
);
   localparam int unsigned      SRC_W    = $clog2(NUM_PARSERS);
   localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_PARSERS - 1);
   localparam logic [SRC_W:0]   NUM_EXT  = (SRC_W+1)'(NUM_PARSERS);

   arb_state_e             r_state;
   arb_state_e             w_state_next;
   logic [PHS_WIDTH-1:0]   r_phs;
   logic [SRC_W-1:0]       r_src;
   logic [SRC_W-1:0]       r_last_grant;
   logic [NUM_PARSERS-1:0] r_drop;
   logic [15:0]            r_drop_cnt;
   logic [NUM_PARSERS-1:0] w_drop;
   logic [NUM_PARSERS-1:0] w_full;
   logic [NUM_PARSERS-1:0] w_empty;
   logic [NUM_PARSERS-1:0] w_pop;
   logic [PHS_WIDTH-1:0]   w_rdata [NUM_PARSERS];
   logic [SRC_W-1:0]       w_winner;
   logic [SRC_W:0]         w_idx;
   logic                   w_found;
   logic                   w_load;
   logic [SRC_W:0]         w_drop_num;
   logic [16:0]            w_cnt_sum;
   logic [15:0]            w_cnt_next;

   for (genvar k = 0; k < NUM_PARSERS; k++) begin : g_fifo
      phs_fifo #(
         .DEPTH (FIFO_DEPTH),
         .WIDTH (PHS_WIDTH)
      ) u_fifo (
         .i_clk   (CLK),
         .i_rst_n (reset_n),
         .i_wr    (bus.phs_valid_i[k]),
         .i_wdata (bus.phs_i[k*PHS_WIDTH +: PHS_WIDTH]),
         .i_rd    (w_pop[k]),
         .o_rdata (w_rdata[k]),
         .o_full  (w_full[k]),
         .o_empty (w_empty[k])
      );

      assign w_pop[k]  = w_load && (w_winner == SRC_W'(k));
      // A pop frees the slot the strobe needs, so only an un-popped full FIFO drops.
      assign w_drop[k] = bus.phs_valid_i[k] && w_full[k] && !w_pop[k];
   end

   // Scan from last_grant+1; the sum never exceeds 2*N-1, so one wrap subtract suffices.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_idx    = '0;
      for (int unsigned i = 1; i <= NUM_PARSERS; i++) begin
         w_idx = {1'b0, r_last_grant} + (SRC_W+1)'(i);
         if (w_idx >= NUM_EXT) w_idx = w_idx - NUM_EXT;
         if (!w_found && !w_empty[w_idx[SRC_W-1:0]]) begin
            w_found  = 1'b1;
            w_winner = w_idx[SRC_W-1:0];
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      unique case (r_state)
         ARB_EMPTY: begin
            if (w_found) begin
               w_load       = 1'b1;
               w_state_next = ARB_HOLD;
            end
         end
         ARB_HOLD: begin
            if (bus.phs_ready_i) begin
               w_load = w_found;
               if (!w_found) w_state_next = ARB_EMPTY;
            end
         end
      endcase
   end

   always_comb begin
      w_drop_num = '0;
      for (int unsigned i = 0; i < NUM_PARSERS; i++) begin
         w_drop_num = w_drop_num + (SRC_W+1)'(w_drop[i]);
      end
      w_cnt_sum  = {1'b0, r_drop_cnt} + 17'(w_drop_num);
      w_cnt_next = w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ARB_EMPTY;
         r_phs        <= '0;
         r_src        <= '0;
         r_last_grant <= LAST_IDX;
         r_drop       <= '0;
         r_drop_cnt   <= '0;
      end else begin
         r_state    <= w_state_next;
         r_drop     <= w_drop;
         r_drop_cnt <= w_cnt_next;
         if (w_load) begin
            r_phs        <= w_rdata[w_winner];
            r_src        <= w_winner;
            r_last_grant <= w_winner;
         end
      end
   end

   assign bus.phs_o       = r_phs;
   assign bus.phs_valid_o = (r_state == ARB_HOLD);
   assign bus.phs_src_o   = r_src;
   assign bus.drop_o      = r_drop;
   assign bus.drop_cnt_o  = r_drop_cnt;

endmodule

// File: tb/tb_phs_arbiter.sv
// Self-checking bench for phs_arbiter: directed vector table, hand sequences and random traffic
// compared cycle by cycle against a queue-based reference model.
module tb_phs_arbiter;
   import parser_typedefs_pkg::*;

   localparam int unsigned NP    = 4;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned PW    = PHS_WIDTH_DEFAULT;

   typedef logic [PW-1:0] word_t;

   typedef struct packed {
      logic [NP-1:0]         mask;
      logic                  rdy;
      logic [NP-1:0][PW-1:0] data;
      logic                  exp_valid;
      logic [1:0]            exp_src;
      logic [PW-1:0]         exp_data;
   } vec_t;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;
   always #5 clk = ~clk;

   phs_arbiter_if #(.NUM_PARSERS(NP), .PHS_WIDTH(PW)) bus ();

   phs_arbiter #(
      .NUM_PARSERS (NP),
      .FIFO_DEPTH  (DEPTH),
      .PHS_WIDTH   (PW)
   ) dut (
      .CLK     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   word_t         mq [NP][$];
   logic          m_valid;
   word_t         m_data;
   int            m_src;
   int            m_last;
   logic [NP-1:0] m_drop;
   int            m_cnt;

   word_t t_data [NP];
   vec_t  vecs [9];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   function automatic word_t word_of(input logic [7:0] b);
      return word_t'({15{b}});
   endfunction

   function automatic word_t rand_word();
      logic [127:0] t;
      t = {$urandom, $urandom, $urandom, $urandom};
      return t[PW-1:0];
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NP; k++) mq[k].delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_src   = 0;
      m_last  = NP - 1;
      m_drop  = '0;
      m_cnt   = 0;
   endtask

   // One clock of the rules: pick winner from pre-edge occupancy, then accept strobes.
   task automatic model_step(input logic [NP-1:0] mask, input logic rdy);
      int win = -1;
      int n   = 0;
      if (!m_valid || rdy) begin
         for (int i = 1; i <= NP; i++) begin
            int idx = (m_last + i) % NP;
            if (win < 0 && mq[idx].size() > 0) win = idx;
         end
      end
      if (win >= 0) begin
         m_data  = mq[win].pop_front();
         m_src   = win;
         m_last  = win;
         m_valid = 1'b1;
      end else if (m_valid && rdy) begin
         m_valid = 1'b0;
      end
      m_drop = '0;
      for (int k = 0; k < NP; k++) begin
         if (mask[k]) begin
            if (mq[k].size() < DEPTH) mq[k].push_back(t_data[k]);
            else begin
               m_drop[k] = 1'b1;
               n++;
            end
         end
      end
      m_cnt = (m_cnt + n > 65535) ? 65535 : m_cnt + n;
   endtask

   task automatic compare_all();
      chk("valid", 128'(bus.phs_valid_o), 128'(m_valid));
      chk("src",   128'(bus.phs_src_o),   128'(m_src));
      chk("data",  128'(bus.phs_o),       128'(m_data));
      chk("drop",  128'(bus.drop_o),      128'(m_drop));
      chk("cnt",   128'(bus.drop_cnt_o),  128'(m_cnt));
   endtask

   task automatic step(input logic [NP-1:0] mask, input logic rdy);
      bus.phs_valid_i = mask;
      bus.phs_ready_i = rdy;
      for (int k = 0; k < NP; k++) bus.phs_i[k*PW +: PW] = t_data[k];
      @(posedge clk);
      model_step(mask, rdy);
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      bus.phs_valid_i = '0;
      bus.phs_ready_i = 1'b0;
      #2 reset_n = 1'b0;
      model_reset();
      #1 compare_all();
      @(posedge clk);
      @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog: got no finish, required finish before %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.phs_i       = '0;
      bus.phs_valid_i = '0;
      bus.phs_ready_i = 1'b0;
      for (int k = 0; k < NP; k++) t_data[k] = '0;

      // Directed table: simultaneous strobes, then a single strobe from parser 2.
      for (int r = 0; r < 9; r++) begin
         vecs[r] = '0;
         vecs[r].rdy = 1'b1;
      end
      vecs[0].mask = 4'b1111;
      for (int k = 0; k < NP; k++) vecs[0].data[k] = word_of(8'(8'h10 + k));
      for (int r = 1; r <= 4; r++) begin
         vecs[r].exp_valid = 1'b1;
         vecs[r].exp_src   = 2'(r - 1);
         vecs[r].exp_data  = word_of(8'(8'h10 + r - 1));
      end
      vecs[6].mask     = 4'b0100;
      vecs[6].data[2]  = word_of(8'hA5);
      vecs[7].exp_valid = 1'b1;
      vecs[7].exp_src   = 2'd2;
      vecs[7].exp_data  = word_of(8'hA5);

      do_reset();
      for (int r = 0; r < 9; r++) begin
         for (int k = 0; k < NP; k++) t_data[k] = vecs[r].data[k];
         step(vecs[r].mask, vecs[r].rdy);
         chk("vec_valid", 128'(bus.phs_valid_o), 128'(vecs[r].exp_valid));
         if (vecs[r].exp_valid) begin
            chk("vec_src",  128'(bus.phs_src_o), 128'(vecs[r].exp_src));
            chk("vec_data", 128'(bus.phs_o),     128'(vecs[r].exp_data));
         end
      end

      // Backpressure: first word held stable, remaining two follow back to back.
      do_reset();
      t_data[1] = word_of(8'h21);
      step(4'b0010, 1'b0);
      t_data[1] = word_of(8'h22);
      step(4'b0010, 1'b0);
      chk("bp_first", 128'(bus.phs_o), 128'(word_of(8'h21)));
      t_data[1] = word_of(8'h23);
      step(4'b0010, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(4'b0000, 1'b0);
         chk("bp_hold_valid", 128'(bus.phs_valid_o), 128'(1));
         chk("bp_hold_data",  128'(bus.phs_o), 128'(word_of(8'h21)));
         chk("bp_hold_src",   128'(bus.phs_src_o), 128'(1));
      end
      step(4'b0000, 1'b1);
      chk("bp_second", 128'(bus.phs_o), 128'(word_of(8'h22)));
      step(4'b0000, 1'b1);
      chk("bp_third", 128'(bus.phs_o), 128'(word_of(8'h23)));
      step(4'b0000, 1'b1);
      chk("bp_empty", 128'(bus.phs_valid_o), 128'(0));

      // Overflow on parser 3 behind a held word from parser 0.
      do_reset();
      t_data[0] = word_of(8'h30);
      step(4'b0001, 1'b0);
      step(4'b0000, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         t_data[3] = word_of(8'(8'h40 + i));
         step(4'b1000, 1'b0);
      end
      chk("ovf_drop", 128'(bus.drop_o), 128'(4'b1000));
      chk("ovf_cnt",  128'(bus.drop_cnt_o), 128'(1));
      step(4'b0000, 1'b0);
      chk("ovf_drop_pulse", 128'(bus.drop_o), 128'(0));
      t_data[3] = word_of(8'h46);
      step(4'b1000, 1'b1);
      chk("ovf_pushpop_drop", 128'(bus.drop_o), 128'(0));
      chk("ovf_pushpop_cnt",  128'(bus.drop_cnt_o), 128'(1));
      chk("ovf_w1", 128'(bus.phs_o), 128'(word_of(8'h41)));
      step(4'b0000, 1'b1);
      chk("ovf_w2", 128'(bus.phs_o), 128'(word_of(8'h42)));
      step(4'b0000, 1'b1);
      chk("ovf_w3", 128'(bus.phs_o), 128'(word_of(8'h43)));
      step(4'b0000, 1'b1);
      chk("ovf_w4", 128'(bus.phs_o), 128'(word_of(8'h44)));
      step(4'b0000, 1'b1);
      chk("ovf_w6", 128'(bus.phs_o), 128'(word_of(8'h46)));
      step(4'b0000, 1'b1);
      chk("ovf_done", 128'(bus.phs_valid_o), 128'(0));

      // Saturation: every parser full and stalled, four drops per cycle.
      do_reset();
      for (int k = 0; k < NP; k++) t_data[k] = rand_word();
      for (int i = 0; i < 16400; i++) step(4'b1111, 1'b0);
      chk("sat_cnt",   128'(bus.drop_cnt_o), 128'(16'hFFFF));
      chk("sat_valid", 128'(bus.phs_valid_o), 128'(1));

      // Asynchronous reset in HOLD, then first post-reset grant goes to parser 0.
      bus.phs_valid_i = '0;
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      chk("rst_valid", 128'(bus.phs_valid_o), 128'(0));
      chk("rst_data",  128'(bus.phs_o), 128'(0));
      chk("rst_src",   128'(bus.phs_src_o), 128'(0));
      chk("rst_drop",  128'(bus.drop_o), 128'(0));
      chk("rst_cnt",   128'(bus.drop_cnt_o), 128'(0));
      @(posedge clk);
      @(posedge clk);
      #1 reset_n = 1'b1;
      step(4'b0000, 1'b1);
      chk("rst_no_stale", 128'(bus.phs_valid_o), 128'(0));
      t_data[0] = word_of(8'h50);
      t_data[3] = word_of(8'h53);
      step(4'b1001, 1'b1);
      step(4'b0000, 1'b1);
      chk("rst_first_src",  128'(bus.phs_src_o), 128'(0));
      chk("rst_first_data", 128'(bus.phs_o), 128'(word_of(8'h50)));
      step(4'b0000, 1'b1);
      chk("rst_second_src", 128'(bus.phs_src_o), 128'(3));

      // Random traffic against the model, with occasional mid-stream resets.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         logic [NP-1:0] m;
         logic          rdy;
         if ($urandom_range(0, 499) == 0) do_reset();
         m   = NP'($urandom) & NP'($urandom);
         rdy = ($urandom_range(0, 9) < 7);
         for (int k = 0; k < NP; k++) t_data[k] = rand_word();
         step(m, rdy);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/phs_arbiter.md
PHS_ARBITER -- requirements
Module: phs_arbiter

Interface
REQ-001 Parameter NUM_PARSERS, default 4, number of parser instances sharing the output; legal range 2..8.
REQ-002 Parameter FIFO_DEPTH, default 4, entries per requester FIFO; power of two, at least 2.
REQ-003 Parameter PHS_WIDTH, default 120, PHS word width in bits (15 bytes).
REQ-004 CLK  input  1  single clock; all state changes on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 phs_i  input  NUM_PARSERS*PHS_WIDTH  PHS word per parser; parser k occupies bits [k*PHS_WIDTH +: PHS_WIDTH].
REQ-007 phs_valid_i  input  NUM_PARSERS  one-cycle strobe per parser; phs_i slice valid only in that cycle.
REQ-008 phs_o  output  PHS_WIDTH  granted PHS word, registered.
REQ-009 phs_valid_o  output  1  phs_o holds a valid word.
REQ-010 phs_ready_i  input  1  downstream accepts phs_o when high together with phs_valid_o.
REQ-011 phs_src_o  output  clog2(NUM_PARSERS)  index of the parser that produced phs_o.
REQ-012 drop_o  output  NUM_PARSERS  one-cycle pulse per parser whose strobe was lost to a full FIFO.
REQ-013 drop_cnt_o  output  16  total dropped words, saturating.

Function
REQ-014 Each parser k SHALL own one FIFO of FIFO_DEPTH x PHS_WIDTH; a phs_valid_i[k] strobe in cycle N SHALL be written at the end of cycle N.
REQ-015 A written word SHALL be eligible for arbitration in cycle N+1; with an empty output register, phs_valid_o SHALL assert in cycle N+2 (2-cycle minimum latency, no bypass).
REQ-016 Output FSM states: EMPTY (phs_valid_o=0) and HOLD (phs_valid_o=1).
REQ-017 EMPTY -> HOLD when at least one FIFO is non-empty: pop the winner, load phs_o and phs_src_o.
REQ-018 HOLD with phs_ready_i=0: phs_o, phs_src_o and phs_valid_o SHALL remain stable.
REQ-019 HOLD with phs_ready_i=1 and any FIFO non-empty: transfer completes and the next winner SHALL load at the same edge, giving one word per cycle with no bubble.
REQ-020 HOLD with phs_ready_i=1 and all FIFOs empty -> EMPTY.
REQ-021 Arbitration SHALL be round-robin: search starts at last_grant+1 mod NUM_PARSERS; the first non-empty FIFO wins; last_grant updates only on a load.
REQ-022 Full FIFO, strobe and pop of the same FIFO in one cycle: the write SHALL be accepted with no drop.
REQ-023 Full FIFO, strobe and no pop: the word SHALL be discarded and the FIFO left unchanged.
REQ-024 Drop reporting: drop_o[k] SHALL pulse in cycle N+1; drop_cnt_o SHALL add the number of drops in that cycle, at most NUM_PARSERS.
REQ-025 drop_cnt_o SHALL saturate at 0xFFFF and never wrap.
REQ-026 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by an extra pointer bit.
REQ-027 Arbitration SHALL depend only on FIFO occupancy, never on phs_i content.

Reset
REQ-028 reset_n low SHALL immediately clear, without waiting for CLK: phs_valid_o=0, phs_o=0, phs_src_o=0, drop_o=0, drop_cnt_o=0, all FIFOs empty, FSM=EMPTY, last_grant=NUM_PARSERS-1 (parser 0 wins first).
REQ-029 Reset asserted mid-transfer SHALL discard all buffered and held words; no partial word SHALL appear after release.
REQ-030 Strobes in the first cycle after reset_n deasserts SHALL be accepted normally.

Structure
REQ-031 PHS_WIDTH default and the output FSM state enum (ARB_EMPTY, ARB_HOLD) SHALL live in parser_typedefs_pkg.
REQ-032 Per-requester storage SHALL be a sub-module phs_fifo (write, read, full, empty; same clock and reset), instantiated NUM_PARSERS times.
REQ-033 The round-robin winner search SHALL be combinational inside phs_arbiter; all outputs SHALL be registered.

Verification
REQ-034 Single strobe: parser 2 strobes phs 0xA5..A5 in cycle 10, ready=1 -> phs_valid_o=1 in cycle 12, phs_src_o=2, phs_o=0xA5..A5 for exactly one cycle.
REQ-035 Simultaneous strobes: parsers 0..3 strobe in the same cycle after reset, ready=1 -> outputs from sources 0,1,2,3 on four consecutive cycles.
REQ-036 Backpressure: ready=0 while parser 1 sends 3 words -> the first word is held stable; ready=1 -> the remaining 2 words follow with no bubble, in order.
REQ-037 Overflow: ready=0, parser 3 sends 5 words with FIFO_DEPTH=4 -> drop_o[3] pulses once, drop_cnt_o=1; draining yields words 1-4; a push into a full FIFO during a pop is not dropped.
REQ-038 Saturation and reset: force 65537 drops -> drop_cnt_o=0xFFFF; assert reset_n low mid-HOLD -> all outputs 0 immediately and the next grant goes to parser 0.
